fod_mmd_phase_meas: RTL and testbench

- Divider-side counterpart of the FOD control word generator.
- Consumes the control words MMD_DCW, RT_DCW and DTC_DCW that the controller issues each output cycle.
- Counts main-PLL clock cycles to produce the FOD divider pulse, which is the clock that drives the controller.
- Time-stamps each output edge against the aux-PLL phase and returns the 3-bit phase measurement PHE that the controller's phase-sync calibration consumes.

---
 rtl/fod_mmd_phase_meas.sv | 132 +++++++++++++
 tb/tb_fod_mmd_phase_meas.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fod_mmd_phase_meas.sv
// FOD multi-modulus divider with output-edge phase measurement.
// Counts main-PLL CLK cycles to form the divider pulse DIV_OUT, and time-stamps each
// output edge (aux phase, retimer half-cycle, DTC fraction) into a 3-bit phase PHE.
// Optional build macro: FOD_PHE_ROUND_EN -- PHE rounds to nearest 45 deg instead of
// truncating. Latency is the same either way.
module fod_mmd_phase_meas #(
  parameter int unsigned AUX_LOG2 = 1,
  parameter int unsigned PF       = 8,
  parameter int unsigned KNORM    = 43019,
  parameter int unsigned MMD_MIN  = 4
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       DIV_EN,
  input  logic [5:0] MMD_DCW,
  input  logic       RT_DCW,
  input  logic [9:0] DTC_DCW,
  output logic       DIV_OUT,
  output logic [2:0] PHE,
  output logic       PHE_VLD
);

  localparam int unsigned TsIntW = AUX_LOG2 + 1;
  localparam int unsigned W      = TsIntW + PF;

  localparam logic [5:0]  MmdMin  = 6'(MMD_MIN);
  localparam logic [9:0]  FracMax = 10'((1 << PF) - 1);
  localparam logic [W-1:0] RndHalf = W'(1 << (W - 4));

  logic [5:0]          r_div_cnt;
  logic                r_div_out;
  logic [AUX_LOG2-1:0] r_phase_cnt;
  logic [TsIntW-1:0]   r_ts_int;
  logic [PF-1:0]       r_frac;
  logic                r_s1_vld;
  logic [2:0]          r_phe;
  logic                r_phe_vld;

  logic                w_reload;
  logic [5:0]          w_mmd_clamped;
  logic [5:0]          w_div_cnt_d;
  logic [25:0]         w_prod;
  logic [9:0]          w_frac_raw;
  logic [PF-1:0]       w_frac;
  logic [W-1:0]        w_ts;
  logic [W-1:0]        w_ts_q;
  logic [2:0]          w_phe;

  // Reload happens on the edge closing the div_cnt == 1 cycle, regardless of DIV_EN.
  assign w_reload      = (r_div_cnt == 6'd1);
  assign w_mmd_clamped = (MMD_DCW < MmdMin) ? MmdMin : MMD_DCW;

  // Next divider count: reload, decrement when enabled, otherwise hold.
  always_comb begin
    w_div_cnt_d = r_div_cnt;
    if (w_reload) begin
      w_div_cnt_d = w_mmd_clamped;
    end else if (DIV_EN) begin
      w_div_cnt_d = r_div_cnt - 6'd1;
    end
  end

  // Divider count and registered pulse; a held count is never 1, so DIV_OUT stays low.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_div_cnt <= MmdMin;
      r_div_out <= 1'b0;
    end else begin
      r_div_cnt <= w_div_cnt_d;
      r_div_out <= (w_div_cnt_d == 6'd1);
    end
  end

  // Free-running aux-phase counter, independent of DIV_EN.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_phase_cnt <= '0;
    end else begin
      r_phase_cnt <= r_phase_cnt + AUX_LOG2'(1);
    end
  end

  // DTC code scaled to a fraction of half a CLK period, saturated at full scale.
  assign w_prod     = 26'(DTC_DCW) * 26'(KNORM);
  assign w_frac_raw = 10'(w_prod >> 16);
  assign w_frac     = (w_frac_raw > FracMax) ? {PF{1'b1}} : PF'(w_frac_raw);

  // Stage 1: capture integer timestamp and fraction on the reload edge.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_ts_int <= '0;
      r_frac   <= '0;
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_reload;
      if (w_reload) begin
        r_ts_int <= {r_phase_cnt, RT_DCW};
        r_frac   <= w_frac;
      end
    end
  end

  // frac < 2^PF, so concatenation equals (ts_int << PF) + frac.
  assign w_ts = {r_ts_int, r_frac};

`ifdef FOD_PHE_ROUND_EN
  // Add half an LSB before dropping bits; overflow past the top wraps 8 to 0.
  assign w_ts_q = w_ts + RndHalf;
`else
  assign w_ts_q = w_ts;
`endif

  assign w_phe = 3'(w_ts_q >> (W - 3));

  // Stage 2: quantised phase and one-cycle strobe; PHE holds between strobes.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_phe     <= 3'd0;
      r_phe_vld <= 1'b0;
    end else begin
      r_phe_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_phe <= w_phe;
      end
    end
  end

  assign DIV_OUT = r_div_out;
  assign PHE     = r_phe;
  assign PHE_VLD = r_phe_vld;

endmodule

// File: tb/tb_fod_mmd_phase_meas.sv
// Self-checking bench for fod_mmd_phase_meas: directed steps then randomized traffic,
// compared each cycle against a cycle-level behavioural model of pulses and phase.
module tb_fod_mmd_phase_meas;

  localparam int AUX_LOG2 = 1;
  localparam int PF       = 8;
  localparam int KNORM    = 43019;
  localparam int MMD_MIN  = 4;
  localparam int W        = AUX_LOG2 + 1 + PF;

  logic       CLK;
  logic       NRST;
  logic       DIV_EN;
  logic [5:0] MMD_DCW;
  logic       RT_DCW;
  logic [9:0] DTC_DCW;
  logic       DIV_OUT;
  logic [2:0] PHE;
  logic       PHE_VLD;

  int checks;
  int errors;

  // Model state: enabled edges left before the next pulse, aux phase, measurement pipe.
  int m_phase;
  int m_left;
  bit m_in_pulse;
  bit m_p1_vld;
  int m_p1_phe;
  bit m_vld;
  int m_phe;

  fod_mmd_phase_meas #(
    .AUX_LOG2(AUX_LOG2),
    .PF      (PF),
    .KNORM   (KNORM),
    .MMD_MIN (MMD_MIN)
  ) dut (
    .CLK    (CLK),
    .NRST   (NRST),
    .DIV_EN (DIV_EN),
    .MMD_DCW(MMD_DCW),
    .RT_DCW (RT_DCW),
    .DTC_DCW(DTC_DCW),
    .DIV_OUT(DIV_OUT),
    .PHE    (PHE),
    .PHE_VLD(PHE_VLD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected phase from the time-stamp definition, in plain arithmetic.
  function automatic int ref_phe(int ph, int rt, int dtc);
    int frac;
    int ts;
    frac = (dtc * KNORM) / 65536;
    if (frac > (1 << PF) - 1) frac = (1 << PF) - 1;
    ts = (ph * 2 + rt) * (1 << PF) + frac;
`ifdef FOD_PHE_ROUND_EN
    return ((ts + (1 << (W - 4))) / (1 << (W - 3))) % 8;
`else
    return ts / (1 << (W - 3));
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("div_out", 32'(DIV_OUT), 32'(m_in_pulse));
    chk("phe_vld", 32'(PHE_VLD), 32'(m_vld));
    chk("phe", 32'(PHE), 32'(m_phe));
  endtask

  task automatic model_reset();
    m_phase    = 0;
    m_left     = MMD_MIN - 1;
    m_in_pulse = 0;
    m_p1_vld   = 0;
    m_p1_phe   = 0;
    m_vld      = 0;
    m_phe      = 0;
  endtask

  // One clock edge: advance the model with the inputs present before the edge, then compare.
  task automatic tick();
    int old_phase;
    bit old_p1;
    int old_p1_phe;
    int n;
    @(posedge CLK);
    old_phase  = m_phase;
    old_p1     = m_p1_vld;
    old_p1_phe = m_p1_phe;
    m_phase    = (m_phase + 1) % (1 << AUX_LOG2);
    if (m_in_pulse) begin
      n          = (int'(MMD_DCW) < MMD_MIN) ? MMD_MIN : int'(MMD_DCW);
      m_left     = n - 1;
      m_in_pulse = 0;
      m_p1_vld   = 1;
      m_p1_phe   = ref_phe(old_phase, int'(RT_DCW), int'(DTC_DCW));
    end else begin
      m_p1_vld = 0;
      if (DIV_EN) begin
        m_left--;
        if (m_left == 0) m_in_pulse = 1;
      end
    end
    m_vld = old_p1;
    if (old_p1) m_phe = old_p1_phe;
    #1;
    chk_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset taken mid-cycle, held across one edge, released mid-cycle.
  task automatic do_reset();
    NRST = 1'b0;
    model_reset();
    #1;
    chk("rst_div_out", 32'(DIV_OUT), 32'd0);
    chk("rst_phe_vld", 32'(PHE_VLD), 32'd0);
    chk("rst_phe", 32'(PHE), 32'd0);
    @(posedge CLK);
    #1;
    chk_model();
    #2;
    NRST = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    NRST    = 1'b0;
    DIV_EN  = 1'b1;
    MMD_DCW = 6'd8;
    RT_DCW  = 1'b0;
    DTC_DCW = 10'd0;
    model_reset();
    #12;
    chk("por_div_out", 32'(DIV_OUT), 32'd0);
    chk("por_phe_vld", 32'(PHE_VLD), 32'd0);
    chk("por_phe", 32'(PHE), 32'd0);
    NRST = 1'b1;

    // First pulse after the 3rd edge, measured phase 4 two edges later.
    ticks(2);
    chk("first_pulse_early", 32'(DIV_OUT), 32'd0);
    tick();
    chk("first_pulse", 32'(DIV_OUT), 32'd1);
    ticks(2);
    chk("first_phe_vld", 32'(PHE_VLD), 32'd1);
    chk("first_phe", 32'(PHE), 32'd4);
    ticks(6);
    chk("period8_pulse", 32'(DIV_OUT), 32'd1);
    ticks(20);

    // Retimer half-cycle: ts = 768.
    RT_DCW = 1'b1;
    ticks(16);
    chk("rt1_phe", 32'(PHE), 32'd6);

    // DTC fraction 128: ts = 640; then saturated 255: ts = 767.
    RT_DCW  = 1'b0;
    DTC_DCW = 10'd195;
    ticks(16);
    chk("dtc195_phe", 32'(PHE), 32'd5);
    DTC_DCW = 10'd1023;
    ticks(16);
`ifdef FOD_PHE_ROUND_EN
    chk("dtc1023_phe", 32'(PHE), 32'd6);
`else
    chk("dtc1023_phe", 32'(PHE), 32'd5);
`endif
    DTC_DCW = 10'd0;

    // Alternate ratios 2 (clamped to 4) and 9 at each pulse.
    for (int i = 0; i < 60; i++) begin
      if (m_in_pulse) MMD_DCW = (MMD_DCW == 6'd2) ? 6'd9 : 6'd2;
      tick();
    end

    // Enable dropped for 5 cycles mid-count.
    MMD_DCW = 6'd8;
    for (int i = 0; i < 12 && !m_in_pulse; i++) tick();
    ticks(3);
    DIV_EN = 1'b0;
    ticks(5);
    DIV_EN = 1'b1;
    ticks(20);

    // Enable falls during the pulse cycle: reload and measurement still complete.
    for (int i = 0; i < 12 && !m_in_pulse; i++) tick();
    DIV_EN = 1'b0;
    ticks(3);
    chk("en_drop_meas", 32'(PHE_VLD), 32'd0);
    DIV_EN = 1'b1;
    ticks(12);

    // Reset with a measurement in flight: no stale strobe, pulse 3 edges after release.
    MMD_DCW = 6'd4;
    ticks(8);
    for (int i = 0; i < 12 && !m_in_pulse; i++) tick();
    tick();
    do_reset();
    tick();
    chk("post_rst_vld1", 32'(PHE_VLD), 32'd0);
    tick();
    chk("post_rst_vld2", 32'(PHE_VLD), 32'd0);
    tick();
    chk("post_rst_pulse", 32'(DIV_OUT), 32'd1);
    ticks(10);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      DIV_EN  = ($urandom_range(0, 7) != 0);
      MMD_DCW = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 12)) : 6'($urandom_range(0, 63));
      RT_DCW  = 1'($urandom_range(0, 1));
      DTC_DCW = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
